// File: rtl/skew_feeder_pkg.sv
// Shared types and helpers for the skew_feeder diagonal-wavefront preload buffer.
package skew_feeder_pkg;

  localparam int DEF_LANES     = 4;
  localparam int DEF_DEPTH     = 8;
  localparam int DEF_BITS      = 32;
  localparam int DEF_SKEW_BASE = 0;

  // Number of enabled shifts needed to push the last data word out of the widest lane.
  function automatic int drain_len(input int lanes, input int depth, input int skew_base);
    return skew_base + lanes - 1 + depth;
  endfunction

  // Default-width slot word; skew_lane declares its own copy sized by BITS.
  typedef struct packed {
    logic                       valid;
    logic signed [DEF_BITS-1:0] data;
  } lane_word_t;

  localparam int CNT_W = $clog2(drain_len(DEF_LANES, DEF_DEPTH, DEF_SKEW_BASE) + 1);

  typedef enum logic {
    ST_IDLE,
    ST_DRAIN
  } feed_state_t;

endpackage

// File: rtl/skew_lane.sv
// One lane of the feeder: SKEW pad slots followed by DEPTH preloaded words, shifted toward slot 0.
module skew_lane #(
  parameter int DEPTH = 8,
  parameter int BITS  = 32,
  parameter int SKEW  = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load,
  input  logic                        shift,
  input  logic [DEPTH-1:0][BITS-1:0]  din,
  output logic signed [BITS-1:0]      q,
  output logic                        q_valid
);

  localparam int unsigned L = SKEW + DEPTH;

  typedef struct packed {
    logic                   valid;
    logic signed [BITS-1:0] data;
  } slot_t;

  slot_t chain    [L];
  slot_t load_img [L];

  always_comb begin
    for (int unsigned i = 0; i < L; i++) load_img[i] = '0;
    for (int unsigned k = 0; k < DEPTH; k++) load_img[SKEW + k] = {1'b1, din[k]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < L; i++) chain[i] <= '0;
    end else if (load) begin
      for (int unsigned i = 0; i < L; i++) chain[i] <= load_img[i];
    end else if (shift) begin
      for (int unsigned i = 0; i + 1 < L; i++) chain[i] <= chain[i + 1];
      chain[L - 1] <= '0;
    end
  end

  assign q       = chain[0].data;
  assign q_valid = chain[0].valid;

endmodule

// File: rtl/skew_feeder.sv
// Multi-lane skewed preload buffer feeding a systolic array edge, with drain tracking.
module skew_feeder
  import skew_feeder_pkg::*;
#(
  parameter int LANES     = 4,
  parameter int DEPTH     = 8,
  parameter int BITS      = 32,
  parameter int SKEW_BASE = 0
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    wr,
  input  logic                                    en,
  input  logic signed [LANES-1:0][DEPTH-1:0][BITS-1:0] d,
  output logic signed [LANES-1:0][BITS-1:0]       q,
  output logic [LANES-1:0]                        q_valid,
  output logic                                    busy,
  output logic                                    done
);

  localparam int N  = drain_len(LANES, DEPTH, SKEW_BASE);
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] N_CNT = CW'(N);

  feed_state_t   state_q, state_d;
  logic [CW-1:0] shift_cnt, cnt_d;
  logic          done_d;
  logic          shift;

  // A load always takes priority over a shift on the same edge.
  assign shift = en && !wr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shift_cnt <= '0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_cnt <= cnt_d;
      done      <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = shift_cnt;
    done_d  = 1'b0;
    if (wr) begin
      state_d = ST_DRAIN;
      cnt_d   = '0;
    end else if (shift && state_q == ST_DRAIN) begin
      cnt_d = shift_cnt + 1'b1;
      if (cnt_d == N_CNT) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
    end
  end

  assign busy = (state_q == ST_DRAIN);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    skew_lane #(
      .DEPTH (DEPTH),
      .BITS  (BITS),
      .SKEW  (SKEW_BASE + l)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .load    (wr),
      .shift   (shift),
      .din     (d[l]),
      .q       (q[l]),
      .q_valid (q_valid[l])
    );
  end

endmodule

// File: tb/tb_skew_feeder.sv
// Self-checking bench for skew_feeder: vector table with scoreboard plus multi-cycle corner sequences.
module tb_skew_feeder;

  localparam int LANES = 4;
  localparam int DEPTH = 4;
  localparam int BITS  = 8;

  logic clk = 1'b0;
  logic rst, wr, en;
  logic signed [LANES-1:0][DEPTH-1:0][BITS-1:0] d;
  logic signed [LANES-1:0][BITS-1:0] q, q2;
  logic [LANES-1:0] qv, qv2;
  logic busy, done, busy2, done2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  skew_feeder #(.LANES(LANES), .DEPTH(DEPTH), .BITS(BITS), .SKEW_BASE(0)) dut (
    .clk(clk), .rst(rst), .wr(wr), .en(en), .d(d),
    .q(q), .q_valid(qv), .busy(busy), .done(done)
  );

  skew_feeder #(.LANES(LANES), .DEPTH(DEPTH), .BITS(BITS), .SKEW_BASE(2)) dut2 (
    .clk(clk), .rst(rst), .wr(wr), .en(en), .d(d),
    .q(q2), .q_valid(qv2), .busy(busy2), .done(done2)
  );

  typedef struct {
    logic       wr;
    logic       en;
    logic [7:0] q0;
    logic [7:0] q3;
    logic [3:0] v;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic w, input logic e, input logic [7:0] q0, input logic [7:0] q3,
                     input logic [3:0] v, input logic b, input logic dn);
    vec_t r;
    r.wr = w; r.en = e; r.q0 = q0; r.q3 = q3; r.v = v; r.busy = b; r.done = dn;
    tbl.push_back(r);
  endtask

  task automatic load_pattern();
    for (int l = 0; l < LANES; l++)
      for (int k = 0; k < DEPTH; k++)
        d[l][k] = 8'(10 * l + k + 1);
  endtask

  task automatic step(input logic w, input logic e);
    wr = w;
    en = e;
    @(posedge clk);
    #1;
    wr = 1'b0;
    en = 1'b0;
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    vec_t e;
    wr = v.wr;
    en = v.en;
    sb.push_back(v);
    @(posedge clk);
    #1;
    wr = 1'b0;
    en = 1'b0;
    if (sb.size() == 0) begin
      chk($sformatf("sb_empty[%0d]", idx), 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk($sformatf("tbl_q0[%0d]", idx),   q[0],  e.q0);
      chk($sformatf("tbl_q3[%0d]", idx),   q[3],  e.q3);
      chk($sformatf("tbl_qv[%0d]", idx),   qv,    e.v);
      chk($sformatf("tbl_busy[%0d]", idx), busy,  e.busy);
      chk($sformatf("tbl_done[%0d]", idx), done,  e.done);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; wr = 1'b0; en = 1'b0; d = '0;

    // Reset held while wr/en toggle: outputs must stay cleared.
    for (int i = 0; i < 6; i++) begin
      for (int l = 0; l < LANES; l++)
        for (int k = 0; k < DEPTH; k++) d[l][k] = 8'($urandom);
      wr = (i % 2 == 0);
      en = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("rst_q[%0d]", i),    q,    '0);
      chk($sformatf("rst_qv[%0d]", i),   qv,   '0);
      chk($sformatf("rst_busy[%0d]", i), busy, 1'b0);
      chk($sformatf("rst_done[%0d]", i), done, 1'b0);
    end
    wr = 1'b0; en = 1'b0;
    rst = 1'b0;

    // Straight drain, then an idle shift.
    add(1, 0, 1, 0,  4'b0001, 1, 0);
    add(0, 1, 2, 0,  4'b0011, 1, 0);
    add(0, 1, 3, 0,  4'b0111, 1, 0);
    add(0, 1, 4, 31, 4'b1111, 1, 0);
    add(0, 1, 0, 32, 4'b1110, 1, 0);
    add(0, 1, 0, 33, 4'b1100, 1, 0);
    add(0, 1, 0, 34, 4'b1000, 1, 0);
    add(0, 1, 0, 0,  4'b0000, 0, 1);
    add(0, 1, 0, 0,  4'b0000, 0, 0);
    // Drain with enable gaps: only asserted enables count.
    add(1, 0, 1, 0,  4'b0001, 1, 0);
    add(0, 1, 2, 0,  4'b0011, 1, 0);
    add(0, 0, 2, 0,  4'b0011, 1, 0);
    add(0, 0, 2, 0,  4'b0011, 1, 0);
    add(0, 1, 3, 0,  4'b0111, 1, 0);
    add(0, 0, 3, 0,  4'b0111, 1, 0);
    add(0, 1, 4, 31, 4'b1111, 1, 0);
    add(0, 1, 0, 32, 4'b1110, 1, 0);
    add(0, 1, 0, 33, 4'b1100, 1, 0);
    add(0, 1, 0, 34, 4'b1000, 1, 0);
    add(0, 0, 0, 34, 4'b1000, 1, 0);
    add(0, 1, 0, 0,  4'b0000, 0, 1);
    add(0, 0, 0, 0,  4'b0000, 0, 0);

    load_pattern();
    for (int i = 0; i < tbl.size(); i++) apply_vec(tbl[i], i);
    chk("sb_drained", sb.size(), 0);

    // Restart with wr & en on the same edge after 3 shifts.
    load_pattern();
    step(1, 0);
    for (int i = 0; i < 3; i++) step(0, 1);
    chk("pre_restart_q3", q[3], 8'd31);
    d = '1;
    step(1, 1);
    chk("restart_q0",   q[0], 8'hFF);
    chk("restart_q1",   q[1], 8'h00);
    chk("restart_q3",   q[3], 8'h00);
    chk("restart_qv",   qv,   4'b0001);
    chk("restart_busy", busy, 1'b1);
    chk("restart_done", done, 1'b0);
    load_pattern();
    for (int s = 1; s <= 7; s++) begin
      step(0, 1);
      chk($sformatf("restart_done_s%0d", s), done, (s == 7));
      chk($sformatf("restart_busy_s%0d", s), busy, (s < 7));
      if (s == 3) chk("restart_q3_s3", q[3], 8'hFF);
      if (s == 1) chk("restart_q0_s1", q[0], 8'hFF);
    end

    // Async reset between edges mid-drain.
    step(1, 0);
    for (int i = 0; i < 5; i++) step(0, 1);
    chk("pre_rst_q3",   q[3], 8'd33);
    chk("pre_rst_busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("async_q",    q,    '0);
    chk("async_qv",   qv,   '0);
    chk("async_busy", busy, 1'b0);
    chk("async_done", done, 1'b0);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(0, 1);
      chk($sformatf("post_rst_q[%0d]", i),    q,    '0);
      chk($sformatf("post_rst_busy[%0d]", i), busy, 1'b0);
      chk($sformatf("post_rst_done[%0d]", i), done, 1'b0);
    end

    // SKEW_BASE=2 instance: per-lane onset, valid count and drain length.
    begin
      int vcnt [LANES];
      int first[LANES];
      for (int l = 0; l < LANES; l++) begin vcnt[l] = 0; first[l] = -1; end
      load_pattern();
      step(1, 0);
      for (int s = 0; s <= 11; s++) begin
        if (s > 0) step(0, 1);
        for (int l = 0; l < LANES; l++) begin
          logic       ev;
          logic [7:0] ed;
          ev = (s >= 2 + l) && (s < 2 + l + DEPTH);
          ed = ev ? 8'(10 * l + (s - 2 - l) + 1) : 8'd0;
          chk($sformatf("sk2_q[l%0d,s%0d]", l, s),  q2[l],  ed);
          chk($sformatf("sk2_qv[l%0d,s%0d]", l, s), qv2[l], ev);
          if (qv2[l]) begin
            vcnt[l]++;
            if (first[l] < 0) first[l] = s;
          end
        end
        chk($sformatf("sk2_done[s%0d]", s), done2, (s == 9));
        chk($sformatf("sk2_busy[s%0d]", s), busy2, (s < 9));
      end
      for (int l = 0; l < LANES; l++) begin
        chk($sformatf("sk2_vcount[l%0d]", l), vcnt[l],  DEPTH);
        chk($sformatf("sk2_first[l%0d]", l),  first[l], 2 + l);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
